// File: rtl/gpio_cmd_responder.sv
// Responder end of the host-to-datapath GPIO link: decodes micro commands into
// switch controls, a timed soft reset, BER counter snapshots and read-back words.
module gpio_cmd_responder #(
    parameter int NB_GPIOS   = 32,
    parameter int NB_CNT     = 64,
    parameter int RST_CYCLES = 16
) (
    input  logic                clock,
    input  logic                i_reset,
    input  logic [NB_GPIOS-1:0] i_gpo,
    output logic [NB_GPIOS-1:0] o_gpi,
    input  logic [NB_CNT-1:0]   i_bit_count_i,
    input  logic [NB_CNT-1:0]   i_err_count_i,
    input  logic [NB_CNT-1:0]   i_bit_count_q,
    input  logic [NB_CNT-1:0]   i_err_count_q,
    output logic [3:0]          o_sw,
    output logic                o_soft_reset,
    output logic                o_busy
);

    localparam int CNT_W = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;

    typedef enum logic [2:0] {
        IDLE,
        DECODE,
        EXEC,
        RST_HOLD,
        WAIT_LOW
    } state_t;

    state_t                state_q, state_d;
    logic                  sync1_q, sync1_d;
    logic                  sync2_q, sync2_d;
    logic                  en_prev_q, en_prev_d;
    logic [1:0]            fill_q, fill_d;
    logic                  armed_q, armed_d;
    logic [7:0]            cmd_q, cmd_d;
    logic [3:0]            data_q, data_d;
    logic [NB_GPIOS-1:0]   gpi_q, gpi_d;
    logic [3:0]            sw_q, sw_d;
    logic                  soft_q, soft_d;
    logic                  busy_q, busy_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [NB_CNT-1:0]     snap_bit_i_q, snap_bit_i_d;
    logic [NB_CNT-1:0]     snap_err_i_q, snap_err_i_d;
    logic [NB_CNT-1:0]     snap_bit_q_q, snap_bit_q_d;
    logic [NB_CNT-1:0]     snap_err_q_q, snap_err_q_d;
    logic                  snap_valid_q, snap_valid_d;

    logic                  rise;
    logic                  err_zero;
    logic [NB_GPIOS-1:0]   exec_word;
    logic                  unused_data;

    assign unused_data = ^i_gpo[22:4];

    // The synchronizer starts from zero after reset, so a low level only counts
    // once two real samples have filled it; otherwise a held-high enable would
    // look like a fresh rising edge.
    assign rise     = sync2_q & ~en_prev_q & armed_q;
    assign err_zero = (snap_err_i_q == '0) && (snap_err_q_q == '0);

    always_comb begin
        exec_word = '0;
        case (cmd_q)
            8'h00:   exec_word = {8'h00, 24'h0};
            8'h01:   exec_word = {8'h01, 24'h0};
            8'h02:   exec_word = {8'h02, 20'h0, data_q};
            8'h03:   exec_word = {8'h03, 24'h1};
            8'h04:   exec_word = snap_bit_i_q[31:0];
            8'h05:   exec_word = snap_bit_i_q[63:32];
            8'h06:   exec_word = snap_err_i_q[31:0];
            8'h07:   exec_word = snap_err_i_q[63:32];
            8'h08:   exec_word = snap_bit_q_q[31:0];
            8'h09:   exec_word = snap_bit_q_q[63:32];
            8'h0A:   exec_word = snap_err_q_q[31:0];
            8'h0B:   exec_word = snap_err_q_q[63:32];
            8'h0C:   exec_word = {8'h0C, 18'h0, snap_valid_q, err_zero, sw_q};
            default: exec_word = {8'hEE, 16'h0, cmd_q};
        endcase
    end

    always_comb begin
        state_d      = state_q;
        sync1_d      = i_gpo[23];
        sync2_d      = sync1_q;
        en_prev_d    = sync2_q;
        fill_d       = {fill_q[0], 1'b1};
        armed_d      = armed_q | (fill_q[1] & ~sync2_q);
        cmd_d        = cmd_q;
        data_d       = data_q;
        gpi_d        = gpi_q;
        sw_d         = sw_q;
        soft_d       = soft_q;
        cnt_d        = cnt_q;
        snap_bit_i_d = snap_bit_i_q;
        snap_err_i_d = snap_err_i_q;
        snap_bit_q_d = snap_bit_q_q;
        snap_err_q_d = snap_err_q_q;
        snap_valid_d = snap_valid_q;

        case (state_q)
            IDLE: begin
                if (rise) begin
                    cmd_d   = i_gpo[31:24];
                    data_d  = i_gpo[3:0];
                    state_d = DECODE;
                end
            end
            DECODE: begin
                if (cmd_q == 8'h01) begin
                    soft_d  = 1'b1;
                    cnt_d   = CNT_W'(RST_CYCLES - 1);
                    state_d = RST_HOLD;
                end else begin
                    state_d = EXEC;
                end
            end
            EXEC: begin
                gpi_d = exec_word;
                if (cmd_q == 8'h02) begin
                    sw_d = data_q;
                end
                if (cmd_q == 8'h03) begin
                    snap_bit_i_d = i_bit_count_i;
                    snap_err_i_d = i_err_count_i;
                    snap_bit_q_d = i_bit_count_q;
                    snap_err_q_d = i_err_count_q;
                    snap_valid_d = 1'b1;
                end
                state_d = WAIT_LOW;
            end
            RST_HOLD: begin
                gpi_d = {8'h01, 24'h0};
                if (cnt_q == '0) begin
                    soft_d  = 1'b0;
                    state_d = WAIT_LOW;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            WAIT_LOW: begin
                if (!sync2_q) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clock or negedge i_reset) begin
        if (!i_reset) begin
            state_q      <= IDLE;
            sync1_q      <= 1'b0;
            sync2_q      <= 1'b0;
            en_prev_q    <= 1'b0;
            fill_q       <= 2'b00;
            armed_q      <= 1'b0;
            cmd_q        <= '0;
            data_q       <= '0;
            gpi_q        <= '0;
            sw_q         <= '0;
            soft_q       <= 1'b0;
            busy_q       <= 1'b0;
            cnt_q        <= '0;
            snap_bit_i_q <= '0;
            snap_err_i_q <= '0;
            snap_bit_q_q <= '0;
            snap_err_q_q <= '0;
            snap_valid_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            sync1_q      <= sync1_d;
            sync2_q      <= sync2_d;
            en_prev_q    <= en_prev_d;
            fill_q       <= fill_d;
            armed_q      <= armed_d;
            cmd_q        <= cmd_d;
            data_q       <= data_d;
            gpi_q        <= gpi_d;
            sw_q         <= sw_d;
            soft_q       <= soft_d;
            busy_q       <= busy_d;
            cnt_q        <= cnt_d;
            snap_bit_i_q <= snap_bit_i_d;
            snap_err_i_q <= snap_err_i_d;
            snap_bit_q_q <= snap_bit_q_d;
            snap_err_q_q <= snap_err_q_d;
            snap_valid_q <= snap_valid_d;
        end
    end

    assign o_gpi        = gpi_q;
    assign o_sw         = sw_q;
    assign o_soft_reset = soft_q;
    assign o_busy       = busy_q;

endmodule

// File: tb/tb_gpio_cmd_responder.sv
// Directed bench for gpio_cmd_responder: drives micro-style command handshakes and
// compares responses against a queue of expected words from a small reference model.
module tb_gpio_cmd_responder;

    localparam int RST_CYCLES = 16;

    logic        clock;
    logic        i_reset;
    logic [31:0] i_gpo;
    logic [31:0] o_gpi;
    logic [63:0] i_bit_count_i, i_err_count_i, i_bit_count_q, i_err_count_q;
    logic [3:0]  o_sw;
    logic        o_soft_reset;
    logic        o_busy;

    int n_checks = 0;
    int n_pass   = 0;
    int n_fail   = 0;
    int busy_rises = 0;
    logic busy_prev = 1'b0;

    logic [31:0] exp_q[$];
    logic [3:0]  m_sw;
    logic [63:0] m_snap[4];
    logic        m_valid;

    gpio_cmd_responder #(.NB_GPIOS(32), .NB_CNT(64), .RST_CYCLES(RST_CYCLES)) dut (
        .clock        (clock),
        .i_reset      (i_reset),
        .i_gpo        (i_gpo),
        .o_gpi        (o_gpi),
        .i_bit_count_i(i_bit_count_i),
        .i_err_count_i(i_err_count_i),
        .i_bit_count_q(i_bit_count_q),
        .i_err_count_q(i_err_count_q),
        .o_sw         (o_sw),
        .o_soft_reset (o_soft_reset),
        .o_busy       (o_busy)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Counts command starts so held-high enables can be shown to run only once.
    always @(posedge clock) begin
        #1;
        if (o_busy && !busy_prev) busy_rises++;
        busy_prev = o_busy;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("[TB] FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_sw    = 4'h0;
        m_valid = 1'b0;
        for (int k = 0; k < 4; k++) m_snap[k] = 64'h0;
    endtask

    function automatic logic [31:0] model_gpi(input logic [7:0] cmd, input logic [22:0] data);
        logic [63:0] w;
        case (cmd)
            8'h00: return 32'h0000_0000;
            8'h01: return 32'h0100_0000;
            8'h02: return {8'h02, 20'h0, data[3:0]};
            8'h03: return 32'h0300_0001;
            8'h04, 8'h05, 8'h06, 8'h07, 8'h08, 8'h09, 8'h0A, 8'h0B: begin
                w = m_snap[(cmd - 8'h04) >> 1];
                return cmd[0] ? w[63:32] : w[31:0];
            end
            8'h0C: return {8'h0C, 18'h0, m_valid, (m_snap[1] == 64'h0 && m_snap[3] == 64'h0), m_sw};
            default: return {8'hEE, 16'h0, cmd};
        endcase
    endfunction

    task automatic wait_busy_rise(output bit ok);
        ok = 1'b0;
        for (int k = 0; k < 20; k++) begin
            @(posedge clock); #1;
            if (o_busy) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    // One full handshake: set cmd/data, raise enable, check timing, read, drop enable.
    task automatic applyStimulus(input logic [7:0] cmd, input logic [22:0] data, input int hold);
        logic [31:0] exp_gpi, got;
        logic [3:0]  sw_old, sw_new;
        int          soft_cnt;
        bit          ok;

        exp_gpi = model_gpi(cmd, data);
        sw_old  = m_sw;
        if (cmd == 8'h02) m_sw = data[3:0];
        if (cmd == 8'h03) begin
            m_snap[0] = i_bit_count_i;
            m_snap[1] = i_err_count_i;
            m_snap[2] = i_bit_count_q;
            m_snap[3] = i_err_count_q;
            m_valid   = 1'b1;
        end
        sw_new = m_sw;
        exp_q.push_back(exp_gpi);

        i_gpo = {cmd, 1'b0, data};
        repeat (2) @(posedge clock);
        #1 i_gpo = {cmd, 1'b1, data};
        wait_busy_rise(ok);
        check($sformatf("busy_rise_%02h", cmd), {31'h0, ok}, 32'h1);
        if (!ok) begin
            void'(exp_q.pop_front());
            i_gpo = 32'h0;
            repeat (10) @(posedge clock);
            return;
        end
        // Scribble cmd/data while busy; the latched copy must be used.
        i_gpo = {8'hA5, 1'b1, 23'h7F_FFFF};
        soft_cnt = 0;
        for (int i = 1; i <= 22; i++) begin
            @(posedge clock); #1;
            if (o_soft_reset) soft_cnt++;
            if (i == 1) check($sformatf("sw_e1_%02h", cmd), {28'h0, o_sw}, {28'h0, sw_old});
            if (i == 2) check($sformatf("sw_e2_%02h", cmd), {28'h0, o_sw}, {28'h0, sw_new});
        end
        check($sformatf("soft_len_%02h", cmd), soft_cnt, (cmd == 8'h01) ? RST_CYCLES : 0);
        repeat (hold) @(posedge clock);
        #1;
        check($sformatf("busy_held_%02h", cmd), {31'h0, o_busy}, 32'h1);
        got = o_gpi;
        checkOutput($sformatf("gpi_%02h", cmd), got);

        i_gpo = {cmd, 1'b0, data};
        ok = 1'b0;
        for (int k = 0; k < 10; k++) begin
            @(posedge clock); #1;
            if (!o_busy) begin
                ok = 1'b1;
                break;
            end
        end
        check($sformatf("busy_fall_%02h", cmd), {31'h0, ok}, 32'h1);
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] got);
        logic [31:0] exp;
        if (exp_q.size() == 0) begin
            check({tag, "_queue"}, 32'h0, 32'h1);
            return;
        end
        exp = exp_q.pop_front();
        check(tag, got, exp);
    endtask

    initial begin
        bit ok;
        int rises_before;

        i_reset       = 1'b0;
        i_gpo         = 32'h0;
        i_bit_count_i = 64'h0;
        i_err_count_i = 64'h0;
        i_bit_count_q = 64'h0;
        i_err_count_q = 64'h0;
        model_reset();

        repeat (3) @(posedge clock);
        #1;
        check("rst_gpi",  o_gpi, 32'h0);
        check("rst_sw",   {28'h0, o_sw}, 32'h0);
        check("rst_soft", {31'h0, o_soft_reset}, 32'h0);
        check("rst_busy", {31'h0, o_busy}, 32'h0);
        @(negedge clock) i_reset = 1'b1;
        repeat (4) @(posedge clock);

        applyStimulus(8'h04, 23'h0, 0);
        applyStimulus(8'h0C, 23'h0, 0);
        applyStimulus(8'h02, 23'h00000B, 0);
        applyStimulus(8'h01, 23'h0, 0);
        applyStimulus(8'h00, 23'h0, 0);

        i_bit_count_i = 64'h1234_5678_9ABC_DEF0;
        i_err_count_i = 64'h0000_0001_FFFF_FFFF;
        i_bit_count_q = 64'hCAFE_F00D_0BAD_BEEF;
        i_err_count_q = 64'h0000_0000_0000_0000;
        applyStimulus(8'h03, 23'h0, 0);
        i_bit_count_i = i_bit_count_i + 64'd1000;
        i_err_count_i = i_err_count_i + 64'd1;
        i_bit_count_q = i_bit_count_q + 64'd77;
        i_err_count_q = i_err_count_q + 64'd5;
        for (int c = 4; c <= 11; c++) applyStimulus(8'(c), 23'h0, 0);
        applyStimulus(8'h0C, 23'h0, 0);
        applyStimulus(8'h7F, 23'h0, 0);

        i_err_count_i = 64'h0;
        i_err_count_q = 64'h0;
        applyStimulus(8'h03, 23'h0, 0);
        applyStimulus(8'h02, 23'h000003, 0);
        applyStimulus(8'h0C, 23'h0, 0);

        rises_before = busy_rises;
        applyStimulus(8'h00, 23'h0, 50);
        check("one_exec_hold", busy_rises - rises_before, 1);

        // Async reset in the middle of the soft-reset pulse.
        i_gpo = {8'h01, 1'b0, 23'h0};
        repeat (2) @(posedge clock);
        #1 i_gpo = {8'h01, 1'b1, 23'h0};
        wait_busy_rise(ok);
        check("rsthold_start", {31'h0, ok}, 32'h1);
        repeat (5) @(posedge clock);
        #1;
        check("rsthold_soft", {31'h0, o_soft_reset}, 32'h1);
        #2 i_reset = 1'b0;
        #1;
        check("midrst_soft", {31'h0, o_soft_reset}, 32'h0);
        check("midrst_busy", {31'h0, o_busy}, 32'h0);
        check("midrst_gpi",  o_gpi, 32'h0);
        check("midrst_sw",   {28'h0, o_sw}, 32'h0);
        model_reset();

        // Enable held high through reset release must not start a command.
        i_gpo = {8'h02, 1'b1, 23'h000005};
        repeat (2) @(posedge clock);
        @(negedge clock) i_reset = 1'b1;
        rises_before = busy_rises;
        repeat (20) @(posedge clock);
        #1;
        check("hi_out_of_rst_busy", {31'h0, o_busy}, 32'h0);
        check("hi_out_of_rst_runs", busy_rises - rises_before, 0);
        check("hi_out_of_rst_sw",   {28'h0, o_sw}, 32'h0);
        i_gpo = 32'h0;
        repeat (5) @(posedge clock);

        applyStimulus(8'h04, 23'h0, 0);
        applyStimulus(8'h0C, 23'h0, 0);

        check("queue_empty", exp_q.size(), 0);
        $display("[TB] %0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
